// File: rtl/acq_hold_ctrl.sv
// ---------------------------------------------------------------------------
// acq_hold_ctrl
//
// Sample-and-hold / ADC front-end sequencer for the configurable modulator.
// A programmable period counter produces one tick every P clock cycles
// (P = shadowed div_val, minimum 2). On each tick taken while idle, the
// sequencer closes the track switch for acq_len cycles (minimum 1), holds
// for SETTLE_CYC cycles, issues a one-cycle conversion start and waits for
// conv_done (or gives up after CONV_TIMEOUT cycles). The captured sample is
// presented on sample_out with a one-cycle sample_valid pulse.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   enable       run sequencer; low aborts to idle and clears the flags
//   div_val      sample period in clk cycles (shadowed on enable rise / wrap)
//   acq_len      acquire window in clk cycles (shadowed when a sequence starts)
//   conv_done    ADC conversion complete, qualifies adc_data
//   adc_data     ADC result
//   clr_flags    clears the sticky overrun and timeout flags
//   acq          track switch closed (S/H acquiring)
//   hold         S/H holding (settle and conversion phases)
//   conv_start   one-cycle ADC start pulse
//   sample_out   last captured sample
//   sample_valid one-cycle pulse, sample_out updated
//   overrun      sticky: a period tick arrived while a sequence was running
//   timeout      sticky: conv_done did not arrive within CONV_TIMEOUT cycles
// ---------------------------------------------------------------------------
module acq_hold_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DATA_W       = 12,
  parameter int SETTLE_CYC   = 4,
  parameter int CONV_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [CNT_W-1:0]  acq_len,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              clr_flags,
  output logic              acq,
  output logic              hold,
  output logic              conv_start,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              overrun,
  output logic              timeout
);

  // Conversion timer only needs to reach CONV_TIMEOUT-1.
  localparam int TO_W = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    SETTLE = 2'd2,
    CONV   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic              enable_d_reg;
  logic [CNT_W-1:0]  period_reg;
  logic [CNT_W-1:0]  period_cnt_reg;
  logic [CNT_W-1:0]  alen_reg;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  phase_cnt_reg;
  logic [CNT_W-1:0]  phase_cnt_next;
  logic [TO_W-1:0]   conv_tmr_reg;
  logic [TO_W-1:0]   conv_tmr_next;

  logic              acq_reg;
  logic              hold_reg;
  logic              conv_start_reg;
  logic [DATA_W-1:0] sample_reg;
  logic              sample_valid_reg;

  logic [1:0]        flags_reg;
  logic [1:0]        flags_next;
  logic [1:0]        flag_set;
  logic              flag_clr;

  logic [CNT_W-1:0]  div_clamped;
  logic [CNT_W-1:0]  alen_clamped;
  logic              en_rise;
  logic              tick;
  logic              start_seq;
  logic              conv_accept;
  logic              conv_expire;
  logic              overrun_set;

  // -------------------------------------------------------------------------
  // Input clamps: a period below 2 would tick every cycle (or never), and a
  // zero-length acquire window would skip tracking altogether.
  // -------------------------------------------------------------------------
  assign div_clamped  = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
  assign alen_clamped = (acq_len == '0) ? CNT_W'(1) : acq_len;

  // -------------------------------------------------------------------------
  // Period counter
  // The enable rising-edge cycle only loads the period shadow; counting
  // starts in the following cycle, so the first tick lands P cycles after
  // the rise. A new period value only takes effect at a wrap, which keeps
  // the period in progress intact when software rewrites div_val.
  // -------------------------------------------------------------------------
  assign en_rise = enable & ~enable_d_reg;
  assign tick    = enable & ~en_rise & (period_cnt_reg == (period_reg - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_d_reg   <= 1'b0;
      period_reg     <= '0;
      period_cnt_reg <= '0;
    end else begin
      enable_d_reg <= enable;
      if (!enable) begin
        period_cnt_reg <= '0;
      end else if (en_rise || tick) begin
        period_reg     <= div_clamped;
        period_cnt_reg <= '0;
      end else begin
        period_cnt_reg <= period_cnt_reg + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      conv_tmr_reg  <= '0;
      alen_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      conv_tmr_reg  <= conv_tmr_next;
      if (start_seq) begin
        alen_reg <= alen_clamped;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM: next state
  // phase_cnt times the ACQ and SETTLE windows; conv_tmr counts cycles
  // since conv_start. conv_tmr == 0 marks the conv_start cycle itself, in
  // which conv_done is not trusted (it may be a stale level from the ADC).
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    conv_tmr_next  = conv_tmr_reg;
    start_seq      = 1'b0;
    conv_accept    = 1'b0;
    conv_expire    = 1'b0;

    if (!enable) begin
      state_next     = IDLE;
      phase_cnt_next = '0;
      conv_tmr_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_next     = ACQ;
            phase_cnt_next = '0;
            start_seq      = 1'b1;
          end
        end

        ACQ: begin
          if (phase_cnt_reg == (alen_reg - CNT_W'(1))) begin
            state_next     = SETTLE;
            phase_cnt_next = '0;
          end else begin
            phase_cnt_next = phase_cnt_reg + CNT_W'(1);
          end
        end

        SETTLE: begin
          if (phase_cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
            state_next     = CONV;
            phase_cnt_next = '0;
            conv_tmr_next  = '0;
          end else begin
            phase_cnt_next = phase_cnt_reg + CNT_W'(1);
          end
        end

        CONV: begin
          // A conv_done arriving in the last allowed cycle still counts.
          if ((conv_tmr_reg != '0) && conv_done) begin
            state_next  = IDLE;
            conv_accept = 1'b1;
          end else if (conv_tmr_reg == TO_W'(CONV_TIMEOUT - 1)) begin
            state_next  = IDLE;
            conv_expire = 1'b1;
          end else begin
            conv_tmr_next = conv_tmr_reg + TO_W'(1);
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Ticks landing in a running sequence are dropped, never queued.
  assign overrun_set = tick & (state_reg != IDLE);

  // -------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they line up with the
  // state they describe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acq_reg          <= 1'b0;
      hold_reg         <= 1'b0;
      conv_start_reg   <= 1'b0;
      sample_valid_reg <= 1'b0;
      sample_reg       <= '0;
    end else begin
      acq_reg          <= (state_next == ACQ);
      hold_reg         <= (state_next == SETTLE) || (state_next == CONV);
      conv_start_reg   <= (state_reg == SETTLE) && (state_next == CONV);
      sample_valid_reg <= conv_accept;
      if (conv_accept) begin
        sample_reg <= adc_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky flags: bit 0 = overrun, bit 1 = timeout. A set in the same cycle
  // as a clear wins. Dropping enable also clears them.
  // -------------------------------------------------------------------------
  assign flag_set = {conv_expire, overrun_set};
  assign flag_clr = clr_flags | ~enable;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag
      assign flags_next[gi] = flag_set[gi] ? 1'b1 :
                              flag_clr     ? 1'b0 : flags_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_reg <= '0;
    end else begin
      flags_reg <= flags_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign acq          = acq_reg;
  assign hold         = hold_reg;
  assign conv_start   = conv_start_reg;
  assign sample_out   = sample_reg;
  assign sample_valid = sample_valid_reg;
  assign overrun      = flags_reg[0];
  assign timeout      = flags_reg[1];

endmodule

// File: doc/acq_hold_ctrl.md
Name: acq_hold_ctrl

Overview:
Programmable sequencer for the sample-and-hold / ADC front end of the configurable modulator. It replaces the fixed 2 kHz acquisition tick with a runtime-programmable sampling period. Each period it runs one cycle of acquire (track), hold-settle and ADC conversion handshake, then presents the captured sample to the modulator datapath. Overrun and conversion-timeout conditions are flagged.

Parameters:
CNT_W, 16, width of period and acquire-length counters
DATA_W, 12, ADC sample width
SETTLE_CYC, 4, hold-settle cycles between acquire end and conversion start (min 1)
CONV_TIMEOUT, 1024, max cycles to wait for conv_done after conv_start

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-low reset
enable  in  1  run sequencer; low = abort and idle
div_val  in  CNT_W  sample period in clk cycles
acq_len  in  CNT_W  acquire window in clk cycles
conv_done  in  1  ADC conversion complete, qualifies adc_data
adc_data  in  DATA_W  ADC result
clr_flags  in  1  clears sticky overrun and timeout
acq  out  1  track switch closed (S/H acquiring)
hold  out  1  S/H holding (settle and conversion phases)
conv_start  out  1  one-cycle ADC start pulse
sample_out  out  DATA_W  last captured sample
sample_valid  out  1  one-cycle pulse, sample_out updated
overrun  out  1  sticky: period tick arrived while busy
timeout  out  1  sticky: conv_done missing within CONV_TIMEOUT

Behaviour:
- Reset (rst low, async): all outputs 0, FSM = IDLE, counters 0, shadow div/acq registers 0.
- All outputs registered. acq and hold never both high.
- Period counter: runs only while enable=1. Counts 0..P-1, where P is the shadow of div_val. tick = 1 for one cycle when count==P-1; count then wraps to 0.
- Shadow registers: div_val is latched on the enable rising edge and at every wrap. acq_len is latched on IDLE->ACQ.
- Clamping: div_val<2 is treated as 2. acq_len=0 is treated as 1.
- FSM states: IDLE, ACQ, SETTLE, CONV.
  - IDLE: acq=0, hold=0. On tick, go to ACQ.
  - ACQ: acq=1 for exactly acq_len cycles, then go to SETTLE.
  - SETTLE: hold=1 for SETTLE_CYC cycles, then go to CONV.
  - CONV: hold=1. conv_start=1 on the first CONV cycle only. conv_done is sampled from the following cycle onward; conv_done in the same cycle as conv_start is ignored.
  - CONV, on conv_done=1: sample_out <= adc_data, sample_valid=1 in the next cycle, FSM goes to IDLE.
  - CONV, if CONV_TIMEOUT cycles elapse without conv_done: timeout<=1, FSM goes to IDLE, no sample_valid, sample_out unchanged.
- Latency: tick at cycle T gives acq high at T+1..T+acq_len. hold rises at T+acq_len+1. conv_start fires at T+acq_len+SETTLE_CYC+1.
- Overrun: a tick while the FSM is not IDLE sets overrun and is dropped. The running sequence continues and no queueing occurs.
- conv_done outside CONV is ignored.
- Flags: overrun and timeout are sticky. Cleared by clr_flags=1 or by enable=0. If a set and a clear occur in the same cycle, set wins.
- Abort: enable=0 forces IDLE and period counter 0 on the next edge. acq, hold and conv_start go to 0. No sample_valid. sample_out is retained.
- Restart: the first tick comes P cycles after enable rises.
- Period shorter than the sequence (P <= acq_len+SETTLE_CYC+conversion time) produces an overrun each period. This is legal; no other protection.

Test Plan:
- Nominal run: div_val=20, acq_len=5, SETTLE_CYC=2, conv_done 3 cycles after conv_start, adc_data=0xABC.
  - Expected: acq high 5 cycles, then hold.
  - Expected: conv_start 2 cycles after acq falls, sample_valid with sample_out=0xABC.
  - Expected: repeats every 20 cycles, overrun=0.
- Reset mid-CONV: assert rst during the CONV state.
  - Expected: all outputs 0 immediately (async).
  - Expected: after release with enable=1, first acq rises at cycle div_val+1.
- Overrun: div_val=8, acq_len=5, SETTLE_CYC=2, conv_done after 4 cycles.
  - Expected: overrun=1 after the second tick; sequence completes; sample_valid every 16 cycles.
  - Expected: clr_flags pulse clears overrun, which re-sets on the next dropped tick.
- Timeout: CONV_TIMEOUT=16, conv_done held low.
  - Expected: timeout=1 exactly 16 cycles after conv_start, FSM returns to IDLE, no sample_valid.
  - Expected: the next tick starts a new ACQ normally.
- Abort and clamps: drop enable during ACQ.
  - Expected: acq=0 next cycle, no conv_start, flags cleared.
  - Expected: div_val=0 behaves as 2, acq_len=0 gives a 1-cycle acq.
- Period change: change div_val 20->50 mid-period.
  - Expected: the current period still ends at 20 cycles, the next period is 50 cycles.
  - Expected: conv_done pulse while IDLE has no effect.
